// File: rtl/mips_muldiv_if.sv
// Request/response bundle between the decoder/register file and the multiply/divide unit.
interface mips_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Define MULDIV_DIV_EN to build the restoring divider (DIV/DIVU); otherwise DIV/DIVU are no-ops.
module mips_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic          clk,
  input logic          rst_n,
  mips_muldiv_if.slave bus
);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;
`ifdef MULDIV_DIV_EN
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;
`else
  typedef enum logic [1:0] {StIdle, StMul, StFix} state_e;
`endif

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Upper half: partial product / partial remainder; lower half: multiplier / dividend-quotient.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic [WIDTH:0]       sum;
`ifdef MULDIV_DIV_EN
  logic                 is_div_q, is_div_d;
  logic                 rneg_q, rneg_d;
  logic                 dbz_q, dbz_d;
  logic [WIDTH:0]       trial;
`endif

  logic                 sgn_op;
  logic [WIDTH-1:0]     a_mag, b_mag;

  // MULT and DIV are the signed encodings (op[0] = 0).
  assign sgn_op = ~bus.op[0];
  assign a_mag  = (sgn_op && bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
  assign b_mag  = (sgn_op && bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    sum     = '0;
`ifdef MULDIV_DIV_EN
    is_div_d = is_div_q;
    rneg_d   = rneg_q;
    dbz_d    = 1'b0;
    trial    = '0;
`endif
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.op)
            OpMult, OpMultu: begin
              opnd_d  = a_mag;
              acc_d   = {{WIDTH{1'b0}}, b_mag};
              neg_d   = sgn_op & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
              cnt_d   = '0;
              state_d = StMul;
`ifdef MULDIV_DIV_EN
              is_div_d = 1'b0;
`endif
            end
`ifdef MULDIV_DIV_EN
            OpDiv, OpDivu: begin
              if (bus.operand_b == '0) begin
                hi_d   = bus.operand_a;
                lo_d   = '1;
                done_d = 1'b1;
                dbz_d  = 1'b1;
              end else begin
                opnd_d   = b_mag;
                acc_d    = {{WIDTH{1'b0}}, a_mag};
                neg_d    = sgn_op & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
                rneg_d   = sgn_op & bus.operand_a[WIDTH-1];
                is_div_d = 1'b1;
                cnt_d    = '0;
                state_d  = StDiv;
              end
            end
`endif
            OpMthi: begin
              hi_d   = bus.operand_a;
              done_d = 1'b1;
            end
            OpMtlo: begin
              lo_d   = bus.operand_a;
              done_d = 1'b1;
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      StMul: begin
        sum   = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q})
                         : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
      end
`ifdef MULDIV_DIV_EN
      StDiv: begin
        // Trial-subtract the divisor from the shifted-in partial remainder; keep it if no borrow.
        trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        if (!trial[WIDTH]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else               acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
      end
`endif
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        cnt_d   = '0;
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          lo_d = neg_q  ? -acc_q[WIDTH-1:0]         : acc_q[WIDTH-1:0];
          hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]   : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
        end
`else
        {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q <= 1'b0;
      rneg_q   <= 1'b0;
      dbz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MULDIV_DIV_EN
      is_div_q <= is_div_d;
      rneg_q   <= rneg_d;
      dbz_q    <= dbz_d;
`endif
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MULDIV_DIV_EN
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed cases plus random ops against an arithmetic model.
module tb_mips_muldiv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mips_muldiv_if #(.WIDTH(32)) bus ();

  mips_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural model: plain 64-bit arithmetic, truncating division as in MIPS.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output bit iter, output bit dz);
    longint sa, sb, p;
    logic [63:0] up;
    iter = 1'b0;
    dz   = 1'b0;
    case (op)
      3'b000: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {model_hi, model_lo} = p;
        iter = 1'b1;
      end
      3'b001: begin
        up = {32'b0, a} * {32'b0, b};
        {model_hi, model_lo} = up;
        iter = 1'b1;
      end
`ifdef MULDIV_DIV_EN
      3'b010, 3'b011: begin
        if (b == 32'd0) begin
          model_hi = a;
          model_lo = 32'hFFFF_FFFF;
          dz = 1'b1;
        end else if (op[0]) begin
          model_lo = a / b;
          model_hi = a % b;
          iter = 1'b1;
        end else begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          model_lo = 32'(sa / sb);
          model_hi = 32'(sa % sb);
          iter = 1'b1;
        end
      end
`endif
      3'b100: model_hi = a;
      3'b101: model_lo = a;
      default: ;
    endcase
  endtask

  // Issue one op and watch 37 cycles: done position/count, busy length, div_by_zero, HI/LO.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    bit iter, dz;
    int busy_n, done_n, dbz_n, done_at;
    model(op, a, b, iter, dz);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.operand_a = a;
    bus.operand_b = b;
    busy_n = 0; done_n = 0; dbz_n = 0; done_at = -1;
    for (int i = 0; i < 37; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        bus.start = 1'b0;
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
      end
      if (inject && i == 5) begin
        bus.start = 1'b1;
        bus.op = 3'b101;
        bus.operand_a = 32'h55;
      end
      if (inject && i == 6) bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      if (bus.div_by_zero) dbz_n++;
    end
    chk({tag, "_done_cnt"}, 64'(done_n), 64'd1);
    chk({tag, "_latency"}, 64'(done_at), iter ? 64'd33 : 64'd0);
    chk({tag, "_busy_cycles"}, 64'(busy_n), iter ? 64'd33 : 64'd0);
    chk({tag, "_dbz_cnt"}, 64'(dbz_n), dz ? 64'd1 : 64'd0);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(model_hi));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(model_lo));
  endtask

  initial begin
    int dcnt;
    logic [2:0] rop;
    logic [31:0] ra, rb;
    bus.start = 1'b0;
    bus.op = 3'b000;
    bus.operand_a = '0;
    bus.operand_b = '0;
    #12;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_max_const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd7, 1'b1);
    chk("mult_neg_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);

`ifdef MULDIV_DIV_EN
    run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_neg_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_100_7", 3'b011, 32'd100, 32'd7, 1'b0);
    chk("divu_const", {bus.hi, bus.lo}, {32'd2, 32'd14});
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf_const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    run_op("divu_zero", 3'b011, 32'd100, 32'd0, 1'b0);
    chk("divu_zero_const", {bus.hi, bus.lo}, {32'd100, 32'hFFFF_FFFF});
`else
    run_op("div_noop", 3'b010, 32'd10, 32'd2, 1'b0);
    chk("div_noop_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
`endif

    // MTHI then MTLO on consecutive edges.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'b100;
    bus.operand_a = 32'h1234_5678;
    @(posedge clk);
    #1;
    chk("mthi_hi", 64'(bus.hi), 64'h1234_5678);
    chk("mthi_done", {bus.done, bus.busy}, 64'b10);
    bus.op = 3'b101;
    bus.operand_a = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("mtlo_lo", 64'(bus.lo), 64'h9ABC_DEF0);
    chk("mtlo_done", {bus.done, bus.busy}, 64'b10);
    chk("mtlo_hi_kept", 64'(bus.hi), 64'h1234_5678);
    @(posedge clk);
    #1;
    chk("mt_done_drop", 64'(bus.done), 64'd0);
    model_hi = 32'h1234_5678;
    model_lo = 32'h9ABC_DEF0;

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'b001;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_hilo", {bus.hi, bus.lo}, 64'd0);
    model_hi = '0;
    model_lo = '0;
    dcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dcnt++;
    end
    chk("arst_no_done", 64'(dcnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("multu_3x5", 3'b001, 32'd3, 32'd5, 1'b0);
    chk("multu_3x5_const", {bus.hi, bus.lo}, 64'd15);

    for (int n = 0; n < 24; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      run_op($sformatf("rnd%0d", n), rop, ra, rb, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register file. Operands come from read_data_1 and read_data_2; the decoder drives start and op.
- Results are read back through hi and lo for MFHI/MFLO.
- Control stalls the pipeline while busy is 1.

Parameters:
- WIDTH, 32, operand/HI/LO width. The iteration count equals WIDTH.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled only when busy=0.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- operand_a  input  WIDTH  rs value (multiplicand/dividend; MTHI/MTLO source).
- operand_b  input  WIDTH  rt value (multiplier/divisor).
- busy  output  1  1 while an iterative op is in flight.
- done  output  1  one-cycle pulse when HI/LO are updated or a no-op completes.
- div_by_zero  output  1  pulses with done for DIV/DIVU when operand_b=0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0. This applies at any time, including mid-operation; the in-flight op is discarded.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1 at edge k:
  - MULT/MULTU: latch |a|, |b| (magnitudes for signed, raw values for unsigned); latch result sign = a[31]^b[31] (signed only); busy=1; go to MUL.
  - DIV/DIVU with b!=0: latch magnitudes; latch quotient sign = a[31]^b[31] and remainder sign = a[31] (signed only); busy=1; go to DIV.
  - DIV/DIVU with b=0: at edge k, hi=a, lo=all ones, done=1, div_by_zero=1. Stay in IDLE; busy stays 0.
  - MTHI: hi=a at edge k. MTLO: lo=a at edge k. done=1 for one cycle; busy stays 0.
  - 11x: done=1 for one cycle; no state change.
- MUL: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator. Edges k+1..k+WIDTH. Then go to FIX.
- DIV: restoring division, one quotient bit per cycle. Edges k+1..k+WIDTH. Then go to FIX.
- FIX, edge k+WIDTH+1:
  - Apply two's-complement negation per the latched signs.
  - MUL writes {hi,lo} = product.
  - DIV writes lo = quotient, hi = remainder.
  - Same edge: busy=0, done=1 (one cycle), return to IDLE.
- Latency: with WIDTH=32, iterative results are visible 33 cycles after the start edge.
- done and div_by_zero are registered pulses, high for exactly one cycle.
- start while busy=1 is ignored; no queueing.
- A new start is accepted in the cycle immediately after done.
- Signed overflow case: -2^31 / -1 gives lo=0x80000000, hi=0. No trap.
- hi and lo hold their values between operations. Only completing ops, MTHI and MTLO write them.
- Operands are latched at start. Changes to operand_a/operand_b during busy have no effect.

Optional Feature:
- Macro: MULDIV_DIV_EN.
- Defined: DIV/DIVU are implemented as above, including the DIV state and the divide-by-zero path.
- Undefined:
  - No divider logic and no DIV state.
  - DIV/DIVU behave as 11x no-ops: done pulses for one cycle, hi/lo unchanged, busy stays 0.
  - div_by_zero is tied to 0.
- Multiply, MTHI and MTLO are identical in both builds.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high for 33 cycles; done once; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). A second start during busy (MTLO 0x55) is ignored: lo is not 0x55 after done.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100 b=7 -> lo=14, hi=2. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100 b=0 -> next edge: hi=100, lo=0xFFFFFFFF; done=1 and div_by_zero=1 for one cycle; busy never rises.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated on the respective edges, two done pulses, busy stays 0.
- Start MULTU, drop rst_n at cycle 10 -> hi=lo=0, busy=0 immediately (asynchronously); no done pulse. A MULTU 3*5 after release -> lo=15, hi=0.
- Build without MULDIV_DIV_EN: DIV 10/2 -> done pulses, hi/lo unchanged, div_by_zero=0.
